jellyvl_synctimer_lock_ctrl: RTL
================================

JELLYVL_SYNCTIMER_LOCK_CTRL -- requirements
Module: jellyvl_synctimer_lock_ctrl

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 64, timer bit width.
REQ-002 SHALL have parameter LIMIT_WIDTH, default TIMER_WIDTH, correction-limit bit width.
REQ-003 SHALL have parameter COUNT_WIDTH, default 8, lock/unlock counter width.
REQ-004 SHALL have ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- param_wide_limit  input  LIMIT_WIDTH  unsigned window half-width while acquiring.
- param_narrow_limit  input  LIMIT_WIDTH  unsigned window half-width while locked.
- param_lock_count  input  COUNT_WIDTH  consecutive in-window samples needed to lock.
- param_unlock_count  input  COUNT_WIDTH  consecutive out-of-window samples needed to drop lock.
- current_time  input  TIMER_WIDTH  local timer value.
- in_time  input  TIMER_WIDTH  reference time sample.
- in_valid  input  1  sample strobe; one per cycle max, no backpressure.
- override_request  input  1  limiter request for forced overwrite.
- param_limit_min  output  LIMIT_WIDTH  signed lower limit to limiter.
- param_limit_max  output  LIMIT_WIDTH  signed upper limit to limiter.
- correct_override  output  1  qualifies correct_time as overwrite, not adjust.
- correct_time  output  TIMER_WIDTH  correction time.
- correct_valid  output  1  correction strobe.
- locked  output  1  high in LOCKED state.
- state  output  2  state code: UNLOCK=0, ACQUIRE=1, LOCKED=2.

Function
REQ-005 SHALL be fully pipelined: in_valid at edge N -> correct_valid at edge N+2; back-to-back samples accepted every cycle.
REQ-006 Stage 1 SHALL register in_time, in_valid and diff = signed(in_time - current_time), modulo 2^TIMER_WIDTH.
REQ-007 Stage 1 SHALL compute abs(diff); most-negative value SHALL count as out of window.
REQ-008 "In window" SHALL mean abs(diff) <= param_narrow_limit zero-extended to TIMER_WIDTH.
REQ-009 Stage 2 SHALL drive correct_time = registered in_time and correct_valid = registered in_valid.
REQ-010 correct_override SHALL be 1 when the stage-2 sample is processed in UNLOCK or with force_pending set; otherwise 0.
REQ-011 force_pending SHALL set on any cycle override_request=1 and clear when a sample is emitted with correct_override=1; simultaneous set and clear -> stays set.
REQ-012 UNLOCK: on stage-2 sample -> emit override, go ACQUIRE, clear good_count and bad_count.
REQ-013 ACQUIRE: in-window sample -> good_count+1; when it reaches max(param_lock_count,1) -> LOCKED, clear counters; out-of-window -> good_count=0.
REQ-014 LOCKED: out-of-window sample -> bad_count+1; when it reaches max(param_unlock_count,1) -> ACQUIRE, clear counters; in-window -> bad_count=0.
REQ-015 Any sample emitted with correct_override=1 in ACQUIRE or LOCKED SHALL move state to ACQUIRE and clear counters; this takes priority over REQ-013/014.
REQ-016 Counters SHALL saturate at 2^COUNT_WIDTH-1.
REQ-017 Limits SHALL be registered from next state: LOCKED -> +/-param_narrow_limit, else +/-param_wide_limit; max = +limit, min = -limit, two's complement in LIMIT_WIDTH.
REQ-018 locked SHALL equal (state == LOCKED), registered.
REQ-019 Parameter inputs SHALL be sampled live; changing them mid-operation SHALL take effect on the next sample or limit update.

Reset
REQ-020 On reset: state=UNLOCK, locked=0, correct_valid=0, correct_override=0, correct_time=0, counters=0, force_pending=0, pipeline valids=0.
REQ-021 On reset: param_limit_min=-param_wide_limit and param_limit_max=+param_wide_limit, tracking the input combinationally until the first clock after release.
REQ-022 Reset mid-pipeline SHALL discard in-flight samples; in_valid during reset SHALL be ignored.

Verification
REQ-023 Bench SHALL cover: reset release, first sample in_time=1000, current_time=0 -> correct_valid 2 cycles later with override=1, correct_time=1000, state=ACQUIRE.
REQ-024 Bench SHALL cover: narrow=10, lock_count=3, three samples diff=+5,-10,+3 -> LOCKED after the third sample, limits +/-10, locked=1.
REQ-025 Bench SHALL cover: LOCKED, unlock_count=2, samples diff=+11,+2,+11,+11 -> still LOCKED after sample 3, ACQUIRE after sample 4, limits +/-wide.
REQ-026 Bench SHALL cover: override_request pulse while LOCKED, then one sample -> override=1, state=ACQUIRE, force_pending cleared.
REQ-027 Bench SHALL cover: wrap-around, current_time=2^64-5, in_time=3 -> diff=+8, treated as in window with narrow=10.
REQ-028 Bench SHALL cover: reset asserted one cycle after in_valid -> no correct_valid emitted; state=UNLOCK.

Source files
------------

// File: rtl/jellyvl_synctimer_lock_ctrl.sv
// Lock controller for the synchronous timer: compares reference time samples
// against the local timer, tracks acquire/lock state and drives the limiter.
module jellyvl_synctimer_lock_ctrl #(
    parameter int unsigned TIMER_WIDTH = 64,
    parameter int unsigned LIMIT_WIDTH = TIMER_WIDTH,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LIMIT_WIDTH-1:0] param_wide_limit,
    input  logic [LIMIT_WIDTH-1:0] param_narrow_limit,
    input  logic [COUNT_WIDTH-1:0] param_lock_count,
    input  logic [COUNT_WIDTH-1:0] param_unlock_count,
    input  logic [TIMER_WIDTH-1:0] current_time,
    input  logic [TIMER_WIDTH-1:0] in_time,
    input  logic                   in_valid,
    input  logic                   override_request,
    output logic [LIMIT_WIDTH-1:0] param_limit_min,
    output logic [LIMIT_WIDTH-1:0] param_limit_max,
    output logic                   correct_override,
    output logic [TIMER_WIDTH-1:0] correct_time,
    output logic                   correct_valid,
    output logic                   locked,
    output logic [1:0]             state
);

    localparam int unsigned CMP_W = (TIMER_WIDTH > LIMIT_WIDTH) ? TIMER_WIDTH : LIMIT_WIDTH;

    typedef enum logic [1:0] {
        ST_UNLOCK  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [COUNT_WIDTH-1:0] r_good_count;
    logic [COUNT_WIDTH-1:0] r_bad_count;
    logic [COUNT_WIDTH-1:0] w_next_good;
    logic [COUNT_WIDTH-1:0] w_next_bad;
    logic                   r_force_pending;

    logic                   r_s1_valid;
    logic [TIMER_WIDTH-1:0] r_s1_time;
    logic [TIMER_WIDTH-1:0] r_s1_abs;
    logic                   r_s1_maxneg;

    logic [LIMIT_WIDTH-1:0] r_limit_max;
    logic [LIMIT_WIDTH-1:0] r_limit_min;
    logic                   r_limit_ready;
    logic                   r_locked;

    // Stage 1 difference and magnitude (modulo timer width)
    logic [TIMER_WIDTH-1:0] w_diff;
    logic                   w_diff_neg;
    logic [TIMER_WIDTH-1:0] w_abs;
    logic                   w_maxneg;

    assign w_diff     = in_time - current_time;
    assign w_diff_neg = w_diff[TIMER_WIDTH-1];
    assign w_abs      = w_diff_neg ? (~w_diff + TIMER_WIDTH'(1)) : w_diff;
    assign w_maxneg   = w_diff_neg && (w_diff[TIMER_WIDTH-2:0] == '0);

    // Stage 1: register the sample and its distance from local time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_time   <= '0;
            r_s1_abs    <= '0;
            r_s1_maxneg <= 1'b0;
        end else begin
            r_s1_valid  <= in_valid;
            r_s1_time   <= in_time;
            r_s1_abs    <= w_abs;
            r_s1_maxneg <= w_maxneg;
        end
    end

    // Stage 2 qualifiers, evaluated against live parameter inputs
    logic                   w_in_window;
    logic                   w_override;
    logic [COUNT_WIDTH-1:0] w_lock_thr;
    logic [COUNT_WIDTH-1:0] w_unlock_thr;
    logic [COUNT_WIDTH-1:0] w_good_inc;
    logic [COUNT_WIDTH-1:0] w_bad_inc;
    logic [LIMIT_WIDTH-1:0] w_limit;

    // The most-negative difference has no positive magnitude, so it is always out of window
    assign w_in_window  = !r_s1_maxneg && (CMP_W'(r_s1_abs) <= CMP_W'(param_narrow_limit));
    assign w_override   = (r_state == ST_UNLOCK) || r_force_pending;
    assign w_lock_thr   = (param_lock_count   == '0) ? COUNT_WIDTH'(1) : param_lock_count;
    assign w_unlock_thr = (param_unlock_count == '0) ? COUNT_WIDTH'(1) : param_unlock_count;
    assign w_good_inc   = (&r_good_count) ? r_good_count : r_good_count + COUNT_WIDTH'(1);
    assign w_bad_inc    = (&r_bad_count)  ? r_bad_count  : r_bad_count  + COUNT_WIDTH'(1);
    assign w_limit      = (w_next_state == ST_LOCKED) ? param_narrow_limit : param_wide_limit;

    // Next-state and counter update for the sample leaving stage 1
    always_comb begin
        w_next_state = r_state;
        w_next_good  = r_good_count;
        w_next_bad   = r_bad_count;
        if (r_s1_valid) begin
            if (w_override) begin
                w_next_state = ST_ACQUIRE;
                w_next_good  = '0;
                w_next_bad   = '0;
            end else begin
                case (r_state)
                    ST_ACQUIRE: begin
                        if (w_in_window) begin
                            if (w_good_inc >= w_lock_thr) begin
                                w_next_state = ST_LOCKED;
                                w_next_good  = '0;
                                w_next_bad   = '0;
                            end else begin
                                w_next_good = w_good_inc;
                            end
                        end else begin
                            w_next_good = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_in_window) begin
                            if (w_bad_inc >= w_unlock_thr) begin
                                w_next_state = ST_ACQUIRE;
                                w_next_good  = '0;
                                w_next_bad   = '0;
                            end else begin
                                w_next_bad = w_bad_inc;
                            end
                        end else begin
                            w_next_bad = '0;
                        end
                    end
                    default: w_next_state = r_state;
                endcase
            end
        end
    end

    // Stage 2: state register, correction outputs and limiter limits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_UNLOCK;
            r_good_count     <= '0;
            r_bad_count      <= '0;
            r_force_pending  <= 1'b0;
            correct_valid    <= 1'b0;
            correct_override <= 1'b0;
            correct_time     <= '0;
            r_locked         <= 1'b0;
            r_limit_max      <= '0;
            r_limit_min      <= '0;
            r_limit_ready    <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_good_count     <= w_next_good;
            r_bad_count      <= w_next_bad;
            // A new request in the same cycle as the clearing sample keeps the flag set
            if (override_request) begin
                r_force_pending <= 1'b1;
            end else if (r_s1_valid && w_override) begin
                r_force_pending <= 1'b0;
            end
            correct_valid    <= r_s1_valid;
            correct_override <= r_s1_valid && w_override;
            correct_time     <= r_s1_time;
            r_locked         <= (w_next_state == ST_LOCKED);
            r_limit_max      <= w_limit;
            r_limit_min      <= LIMIT_WIDTH'(0) - w_limit;
            r_limit_ready    <= 1'b1;
        end
    end

    // Until the first registered update, limits follow the wide limit input directly
    assign param_limit_max = r_limit_ready ? r_limit_max : param_wide_limit;
    assign param_limit_min = r_limit_ready ? r_limit_min : (LIMIT_WIDTH'(0) - param_wide_limit);
    assign locked          = r_locked;
    assign state           = r_state;

endmodule
